// File: rtl/if_id_queue_pkg.sv
// Shared CPU definitions: ALU opcodes plus the fetch/decode queue entry type.
package if_id_queue_pkg;

  // Default number of entries held between fetch and decode.
  localparam int unsigned IfIdDepth = 4;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_e;

  // One fetched instruction travelling from IF to ID.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle, including the flush controls and occupancy.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfIdDepth
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            push_valid;
  logic            push_ready;
  logic [31:0]     push_pc;
  logic [31:0]     push_ins;
  logic            push_adel;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [31:0]     out_ins;
  logic            out_adel;
  logic            exc_flush;
  logic            br_flush;
  logic [CntW-1:0] count;

  // Pipeline side: fetch pushes, decode pops and issues flushes.
  modport master (
    output push_valid, push_pc, push_ins, push_adel, out_ready, exc_flush, br_flush,
    input  push_ready, out_valid, out_pc, out_ins, out_adel, count
  );

  // Queue side.
  modport slave (
    input  push_valid, push_pc, push_ins, push_adel, out_ready, exc_flush, br_flush,
    output push_ready, out_valid, out_pc, out_ins, out_adel, count
  );

endinterface

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode with branch delay-slot
// retention and exception flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfIdDepth
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {
    StNormal,
    StWaitDs
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem [DEPTH];
  entry_t          push_entry;
  entry_t          head_entry;
  logic            wr_en;
  logic            push;
  logic            pop;

  assign push_entry = '{pc: bus.push_pc, ins: bus.push_ins, adel: bus.push_adel};
  assign head_entry = mem[head_q];

  assign bus.push_ready = (count_q < CntW'(DEPTH));
  assign bus.out_valid  = (count_q != '0);
  assign bus.count      = count_q;
  assign push           = bus.push_valid && bus.push_ready;
  assign pop            = bus.out_valid && bus.out_ready;

  // Head entry is zeroed when empty so decode never sees stale storage.
  always_comb begin
    bus.out_pc   = '0;
    bus.out_ins  = '0;
    bus.out_adel = 1'b0;
    if (bus.out_valid) begin
      bus.out_pc   = head_entry.pc;
      bus.out_ins  = head_entry.ins;
      bus.out_adel = head_entry.adel;
    end
  end

  // Next pointers, occupancy and state; exception beats branch beats plain push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    wr_en   = 1'b0;
    if (bus.exc_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = StNormal;
    end else if (bus.br_flush && pop) begin
      if (count_q > CntW'(1)) begin
        // Entry behind the branch is its delay slot; drop everything younger.
        head_d  = head_q + PtrW'(1);
        tail_d  = head_q + PtrW'(2);
        count_d = CntW'(1);
        state_d = StNormal;
      end else if (push) begin
        // Queue drains this cycle; the word arriving now is the delay slot.
        wr_en   = 1'b1;
        head_d  = tail_q;
        tail_d  = tail_q + PtrW'(1);
        count_d = CntW'(1);
        state_d = StNormal;
      end else begin
        // Delay slot not fetched yet; the next accepted push will be it.
        head_d  = head_q + PtrW'(1);
        tail_d  = head_q + PtrW'(1);
        count_d = '0;
        state_d = StWaitDs;
      end
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (state_q == StWaitDs && push) begin
        state_d = StNormal;
      end
    end
  end

  // Control state; async reset empties the queue without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StNormal;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_q] <= push_entry;
    end
  end

  // A branch flush is only meaningful on the cycle its instruction leaves the queue.
  br_flush_needs_pop : assert property (
    @(posedge clk) disable iff (rst) (bus.br_flush && !bus.exc_flush) |-> pop
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-level scoreboard.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned D = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  entry_t sb[$];

  if_id_queue_if #(.DEPTH(D)) bus ();

  if_id_queue #(.DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard contents.
  task automatic check_outputs(input string tag);
    entry_t h;
    h = '0;
    if (sb.size() != 0) h = sb[0];
    chk({tag, ".count"}, 32'(bus.count), 32'(sb.size()));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
    chk({tag, ".push_ready"}, 32'(bus.push_ready), 32'(sb.size() < D));
    chk({tag, ".out_pc"}, bus.out_pc, h.pc);
    chk({tag, ".out_ins"}, bus.out_ins, h.ins);
    chk({tag, ".out_adel"}, 32'(bus.out_adel), 32'(h.adel));
  endtask

  // One clock cycle: drive, check pre-edge outputs, update the model, clock.
  task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic adel, input logic ordy,
                      input logic exc, input logic br);
    entry_t e;
    entry_t keep;
    bit acc;
    bit pp;
    bus.push_valid = pv;
    bus.push_pc    = pc;
    bus.push_ins   = ins;
    bus.push_adel  = adel;
    bus.out_ready  = ordy;
    bus.exc_flush  = exc;
    bus.br_flush   = br;
    #1;
    check_outputs(tag);
    e.pc = pc;
    e.ins = ins;
    e.adel = adel;
    acc = pv && (sb.size() < D);
    pp  = ordy && (sb.size() != 0);
    if (exc) begin
      sb.delete();
    end else if (br && pp) begin
      void'(sb.pop_front());
      if (sb.size() > 0) begin
        keep = sb[0];
        sb.delete();
        sb.push_back(keep);
      end else if (acc) begin
        sb.push_back(e);
      end
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.push_valid = 1'b0;
    bus.push_pc    = '0;
    bus.push_ins   = '0;
    bus.push_adel  = 1'b0;
    bus.out_ready  = 1'b0;
    bus.exc_flush  = 1'b0;
    bus.br_flush   = 1'b0;
    #13;
    chk("reset.count", 32'(bus.count), 32'd0);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.push_ready", 32'(bus.push_ready), 32'd1);
    chk("reset.out_pc", bus.out_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to capacity, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      step("fill", 1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'(i), 1'b0,
           1'b0, 1'b0);
    end
    chk("fill.count4", 32'(bus.count), 32'd4);
    chk("fill.ready0", 32'(bus.push_ready), 32'd0);
    step("fill5", 1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill5.count", 32'(bus.count), 32'd4);
    chk("fill5.head", bus.out_pc, 32'hBFC0_0000);
    // Full with simultaneous pop: push still refused.
    step("full_pp", 1'b1, 32'hBFC0_0014, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_pp.count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain.count", 32'(bus.count), 32'd0);

    // Stream through the queue long enough to wrap the pointers twice.
    for (int i = 0; i < 9; i++) begin
      step("stream", 1'b1, 32'h0000_1000 + 32'(4 * i), ~32'(i), 1'(i >> 1), 1'b1,
           1'b0, 1'b0);
      chk("stream.count1", 32'(bus.count), 32'd1);
      chk("stream.pc", bus.out_pc, 32'h0000_1000 + 32'(4 * i));
    end
    step("stream_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Branch with delay slot already queued.
    step("brA", 1'b1, 32'h0000_A000, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step("brB", 1'b1, 32'h0000_B000, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0);
    step("brC", 1'b1, 32'h0000_C000, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_pop", 1'b1, 32'h0000_E000, 32'h4444_4444, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("br_slot.count", 32'(bus.count), 32'd1);
    chk("br_slot.pc", bus.out_pc, 32'h0000_B000);
    chk("br_slot.adel", 32'(bus.out_adel), 32'd1);
    step("br_slot_pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Branch whose delay slot has not been fetched.
    step("wdA", 1'b1, 32'h0000_A100, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wd_pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wd.count0", 32'(bus.count), 32'd0);
    chk("wd.ready", 32'(bus.push_ready), 32'd1);
    step("wdD", 1'b1, 32'h0000_D000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wdD.valid", 32'(bus.out_valid), 32'd1);
    chk("wdD.pc", bus.out_pc, 32'h0000_D000);
    chk("wdD.ins", bus.out_ins, 32'h0000_0000);
    step("wdE", 1'b1, 32'h0000_D004, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wdE.count2", 32'(bus.count), 32'd2);

    // Branch on the last entry with the delay slot arriving the same cycle.
    step("bpD", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("bp_pop", 1'b1, 32'h0000_F000, 32'h7777_7777, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp.count1", 32'(bus.count), 32'd1);
    chk("bp.pc", bus.out_pc, 32'h0000_F000);
    step("bp_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Exception flush beats branch flush and drops a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      step("exq", 1'b1, 32'h0000_3000 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step("exc", 1'b1, 32'h0000_9000, 32'h9999_9999, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("exc.count0", 32'(bus.count), 32'd0);
    chk("exc.valid0", 32'(bus.out_valid), 32'd0);
    step("exc_after", 1'b1, 32'h0000_9100, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exc_after.pc", bus.out_pc, 32'h0000_9100);
    chk("exc_after.count", 32'(bus.count), 32'd1);

    // Asynchronous reset between clock edges.
    step("ar1", 1'b1, 32'h0000_4004, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar2", 1'b1, 32'h0000_4008, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.push_valid = 1'b0;
    chk("ar.count3", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.valid0", 32'(bus.out_valid), 32'd0);
    chk("ar.count0", 32'(bus.count), 32'd0);
    chk("ar.ready1", 32'(bus.push_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 1'b1, 32'h0000_5000, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
